// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver constants and FSM state type.
// The S_PARITY state exists only when UART_PARITY_EN is defined.
package uart_pkg;
  localparam int OVS_RATE  = 16;
  localparam int DATA_BITS = 8;
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } rx_state_t;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: one-cycle oversample tick every CLKS_PER_TICK clocks.
// The restart input realigns the tick phase to the start-bit edge.
module uart_baud_tick #(
  parameter int CLKS_PER_TICK = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);
  localparam int W = CLKS_PER_TICK > 1 ? $clog2(CLKS_PER_TICK) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(CLKS_PER_TICK - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= restart || tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: 16x oversampling UART receiver with ready/valid byte output.
// Define UART_PARITY_EN for 8E1 framing with PARITY_ERR; otherwise 8N1.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int CLKS_PER_TICK = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RX_SERIAL,
  input  logic       RX_READY,
  output logic [7:0] RX_DOUT,
  output logic       RX_VALID,
  output logic       FRAME_ERR,
  output logic       OVERRUN,
  output logic       PARITY_ERR
);
  rx_state_t state, state_n;
  logic [1:0] sync;
  logic rx, tick, restart, mid, commit, ferr;
  logic [3:0] ovs;
  logic [2:0] bits;
  logic [DATA_BITS-1:0] shift;
  assign rx = sync[1];
  uart_baud_tick #(.CLKS_PER_TICK(CLKS_PER_TICK)) u_tick (
    .clk(CLK),
    .rst_n(RESET),
    .restart(restart),
    .tick(tick)
  );
  // start bit is sampled half a bit in; every later sample is a full bit apart
  assign mid = tick && ovs == (state == S_START ? 4'(OVS_RATE/2 - 1) : 4'(OVS_RATE - 1));
  assign restart = state == S_IDLE && !rx;
  assign commit = state == S_STOP && mid && rx;
  assign ferr = state == S_STOP && mid && !rx;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:      state_n = rx ? S_IDLE : S_START;
      S_START:     if (mid) state_n = rx ? S_IDLE : S_DATA;
`ifdef UART_PARITY_EN
      S_DATA:      if (mid && bits == 3'(DATA_BITS - 1)) state_n = S_PARITY;
      S_PARITY:    if (mid) state_n = S_STOP;
`else
      S_DATA:      if (mid && bits == 3'(DATA_BITS - 1)) state_n = S_STOP;
`endif
      S_STOP:      if (mid) state_n = rx ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: state_n = rx ? S_IDLE : S_WAIT_HIGH;
      default:     state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state     <= S_IDLE;
      sync      <= 2'b11;
      ovs       <= '0;
      bits      <= '0;
      shift     <= '0;
      RX_DOUT   <= '0;
      RX_VALID  <= 1'b0;
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      state     <= state_n;
      sync      <= {sync[0], RX_SERIAL};
      ovs       <= restart || mid ? '0 : ovs + 4'(tick);
      bits      <= restart ? '0 : bits + 3'(state == S_DATA && mid);
      if (state == S_DATA && mid) shift <= {rx, shift[DATA_BITS-1:1]};
      if (commit) RX_DOUT <= shift;
      RX_VALID  <= commit || (RX_VALID && !RX_READY);
      FRAME_ERR <= ferr;
      OVERRUN   <= commit && RX_VALID && !RX_READY;
    end
`ifdef UART_PARITY_EN
  logic par;
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      par        <= 1'b0;
      PARITY_ERR <= 1'b0;
    end else begin
      if (state == S_PARITY && mid) par <= rx;
      PARITY_ERR <= commit && (par != ^shift);
    end
`else
  assign PARITY_ERR = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb_uart_rx_oversample: table-driven, hand-written and random frame checks
// against a transaction-level receiver model; honours UART_PARITY_EN.
module tb_uart_rx_oversample;
  import uart_pkg::*;
  localparam int BIT = 64;
  logic       CLK = 0, RESET = 0, RX_SERIAL = 1, RX_READY = 0;
  logic [7:0] RX_DOUT;
  logic       RX_VALID, FRAME_ERR, OVERRUN, PARITY_ERR;
  int errors = 0, checks = 0;
  int vcyc = 0, fe_n = 0, ov_n = 0, pe_n = 0;
  int b_v, b_fe, b_ov, b_pe;
`ifdef UART_PARITY_EN
  logic par_flip = 0;
`endif

  uart_rx_oversample #(.CLKS_PER_TICK(4)) dut (
    .CLK(CLK), .RESET(RESET), .RX_SERIAL(RX_SERIAL), .RX_READY(RX_READY),
    .RX_DOUT(RX_DOUT), .RX_VALID(RX_VALID), .FRAME_ERR(FRAME_ERR),
    .OVERRUN(OVERRUN), .PARITY_ERR(PARITY_ERR)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (RX_VALID) vcyc++;
    if (FRAME_ERR) fe_n++;
    if (OVERRUN) ov_n++;
    if (PARITY_ERR) pe_n++;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       ready;
    int         gap;
    logic [7:0] exp_dout;
    logic       exp_valid;
    int         exp_fe;
    int         exp_ov;
    int         exp_vcyc;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    RX_SERIAL = 1;
    repeat (n) @(negedge CLK);
  endtask

  task automatic drv(input logic v);
    RX_SERIAL = v;
    repeat (BIT) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drv(0);
    for (int i = 0; i < 8; i++) drv(d[i]);
`ifdef UART_PARITY_EN
    drv(^d ^ par_flip);
`endif
    drv(stop);
  endtask

  task automatic prep(input logic ready);
    RX_READY = ready;
    if (ready) repeat (2) @(negedge CLK);
    b_v = vcyc; b_fe = fe_n; b_ov = ov_n; b_pe = pe_n;
  endtask

  logic [7:0] m_dout, d;
  logic       m_pend, stp, rdy;
  int         gap;

  initial begin
    tbl[0] = '{8'hA5, 1'b1, 1'b1, 0,  8'hA5, 1'b0, 0, 0, 1};
    tbl[1] = '{8'h3C, 1'b0, 1'b1, 64, 8'hA5, 1'b0, 1, 0, 0};
    tbl[2] = '{8'h5A, 1'b1, 1'b1, 0,  8'h5A, 1'b0, 0, 0, 1};
    tbl[3] = '{8'h11, 1'b1, 1'b0, 0,  8'h11, 1'b1, 0, 0, -1};
    tbl[4] = '{8'h22, 1'b1, 1'b0, 0,  8'h22, 1'b1, 0, 1, -1};
    tbl[5] = '{8'h33, 1'b1, 1'b1, 0,  8'h33, 1'b0, 0, 0, 1};
    repeat (5) @(negedge CLK);
    chk("reset_dout", RX_DOUT, 0);
    chk("reset_valid", RX_VALID, 0);
    chk("reset_ferr", FRAME_ERR, 0);
    chk("reset_ovr", OVERRUN, 0);
    chk("reset_perr", PARITY_ERR, 0);
    RESET = 1;
    idle(20);
    for (int i = 0; i < 6; i++) begin
      prep(tbl[i].ready);
      send_frame(tbl[i].data, tbl[i].stop);
      chk($sformatf("tbl%0d_dout", i), RX_DOUT, tbl[i].exp_dout);
      chk($sformatf("tbl%0d_valid", i), RX_VALID, tbl[i].exp_valid);
      chk($sformatf("tbl%0d_ferr", i), fe_n - b_fe, tbl[i].exp_fe);
      chk($sformatf("tbl%0d_ovr", i), ov_n - b_ov, tbl[i].exp_ov);
      chk($sformatf("tbl%0d_perr", i), pe_n - b_pe, 0);
      if (tbl[i].exp_vcyc >= 0) chk($sformatf("tbl%0d_vcyc", i), vcyc - b_v, tbl[i].exp_vcyc);
      idle(tbl[i].gap);
    end

    prep(1);
    RX_SERIAL = 0;
    repeat (20) @(negedge CLK);
    idle(700);
    chk("glitch_vcyc", vcyc - b_v, 0);
    chk("glitch_ferr", fe_n - b_fe, 0);
    chk("glitch_state", int'(dut.state), int'(S_IDLE));

    prep(1);
    drv(0);
    for (int i = 0; i < 4; i++) drv(i < 3);
    repeat (BIT / 2) @(negedge CLK);
    RESET = 0;
    repeat (3) @(negedge CLK);
    chk("rst_mid_dout", RX_DOUT, 0);
    chk("rst_mid_valid", RX_VALID, 0);
    chk("rst_mid_state", int'(dut.state), int'(S_IDLE));
    RX_SERIAL = 1;
    @(negedge CLK);
    RESET = 1;
    idle(100);
    chk("rst_quiet_vcyc", vcyc - b_v, 0);
    prep(1);
    send_frame(8'h0F, 1);
    chk("rst_new_dout", RX_DOUT, 8'h0F);
    chk("rst_new_vcyc", vcyc - b_v, 1);
    chk("rst_new_ferr", fe_n - b_fe, 0);

    m_dout = 8'h0F;
    m_pend = 0;
    for (int i = 0; i < 20; i++) begin
      d   = 8'($urandom);
      stp = $urandom_range(0, 9) != 0;
      rdy = 1'($urandom_range(0, 1));
      gap = stp ? ($urandom_range(0, 1) ? 0 : $urandom_range(1, 100)) : 64;
      if (rdy) m_pend = 0;
      prep(rdy);
      send_frame(d, stp);
      chk($sformatf("rnd%0d_ovr", i), ov_n - b_ov, int'(stp && m_pend && !rdy));
      chk($sformatf("rnd%0d_ferr", i), fe_n - b_fe, int'(!stp));
      if (stp) begin
        m_dout = d;
        m_pend = !rdy;
      end
      chk($sformatf("rnd%0d_dout", i), RX_DOUT, m_dout);
      chk($sformatf("rnd%0d_valid", i), RX_VALID, m_pend);
      chk($sformatf("rnd%0d_perr", i), pe_n - b_pe, 0);
      idle(gap);
    end

`ifdef UART_PARITY_EN
    idle(10);
    par_flip = 1;
    prep(1);
    send_frame(8'h03, 1);
    par_flip = 0;
    chk("par_dout", RX_DOUT, 8'h03);
    chk("par_vcyc", vcyc - b_v, 1);
    chk("par_perr", pe_n - b_pe, 1);
    chk("par_ferr", fe_n - b_fe, 0);
`endif

    idle(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
